// File: rtl/wb_arbiter.sv
// Two-master, one-slave Wishbone arbiter with round-robin tie-break,
// locked-cycle ownership and a stalled-strobe bus-error timeout.
module wb_arbiter #(
  parameter int unsigned addr_width     = 32,
  parameter int unsigned data_width     = 32,
  parameter int unsigned timeout_cycles = 255
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [addr_width-1:0]     m0_adr,
  input  logic [data_width-1:0]     m0_datwr,
  input  logic [data_width/8-1:0]   m0_sel,
  input  logic                      m0_we,
  input  logic                      m0_stb,
  input  logic                      m0_cyc,
  output logic [data_width-1:0]     m0_datrd,
  output logic                      m0_ack,
  output logic                      m0_err,
  input  logic [addr_width-1:0]     m1_adr,
  input  logic [data_width-1:0]     m1_datwr,
  input  logic [data_width/8-1:0]   m1_sel,
  input  logic                      m1_we,
  input  logic                      m1_stb,
  input  logic                      m1_cyc,
  output logic [data_width-1:0]     m1_datrd,
  output logic                      m1_ack,
  output logic                      m1_err,
  output logic [addr_width-1:0]     s_adr,
  output logic [data_width-1:0]     s_datwr,
  output logic [data_width/8-1:0]   s_sel,
  output logic                      s_we,
  output logic                      s_stb,
  output logic                      s_cyc,
  input  logic [data_width-1:0]     s_datrd,
  input  logic                      s_ack,
  output logic [1:0]                grant
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] STALL_LIMIT = CNT_W'(timeout_cycles - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             last_owner_q, last_owner_d;  // 0 = m0, 1 = m1
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             own_stb_c;
  logic             timeout_c;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      stall_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      stall_q      <= stall_d;
    end
  end

  assign own_stb_c = (state_q == OWN0) ? m0_stb :
                     (state_q == OWN1) ? m1_stb : 1'b0;
  assign timeout_c = own_stb_c && !s_ack && (stall_q == STALL_LIMIT);
  assign grant     = {state_q == OWN1, state_q == OWN0};

  // Ownership only changes via IDLE, so two owners are always one cycle apart.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    case (state_q)
      IDLE: begin
        if (m0_cyc && m1_cyc) state_d = last_owner_q ? OWN0 : OWN1;
        else if (m0_cyc)      state_d = OWN0;
        else if (m1_cyc)      state_d = OWN1;
      end
      OWN0: begin
        if (!m0_cyc) begin
          state_d      = IDLE;
          last_owner_d = 1'b0;
        end
      end
      OWN1: begin
        if (!m1_cyc) begin
          state_d      = IDLE;
          last_owner_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall_d = stall_q;
    if (state_q == IDLE || state_d == IDLE || !own_stb_c || s_ack || timeout_c)
      stall_d = '0;
    else
      stall_d = stall_q + CNT_W'(1);
  end

  // Request/response steering; the timeout cycle suppresses the strobe.
  always_comb begin
    s_adr    = '0;
    s_datwr  = '0;
    s_sel    = '0;
    s_we     = 1'b0;
    s_stb    = 1'b0;
    s_cyc    = 1'b0;
    m0_datrd = '0;
    m0_ack   = 1'b0;
    m0_err   = 1'b0;
    m1_datrd = '0;
    m1_ack   = 1'b0;
    m1_err   = 1'b0;
    case (state_q)
      OWN0: begin
        s_adr    = m0_adr;
        s_datwr  = m0_datwr;
        s_sel    = m0_sel;
        s_we     = m0_we;
        s_stb    = m0_stb && !timeout_c;
        s_cyc    = m0_cyc;
        m0_datrd = s_datrd;
        m0_ack   = s_ack;
        m0_err   = timeout_c;
      end
      OWN1: begin
        s_adr    = m1_adr;
        s_datwr  = m1_datwr;
        s_sel    = m1_sel;
        s_we     = m1_we;
        s_stb    = m1_stb && !timeout_c;
        s_cyc    = m1_cyc;
        m1_datrd = s_datrd;
        m1_ack   = s_ack;
        m1_err   = timeout_c;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: arbitration, locking, timeout and reset.
module tb_wb_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;

  logic          clock = 1'b0;
  logic          reset;
  logic [AW-1:0] m0_adr, m1_adr, s_adr;
  logic [DW-1:0] m0_datwr, m1_datwr, s_datwr;
  logic [SW-1:0] m0_sel, m1_sel, s_sel;
  logic          m0_we, m0_stb, m0_cyc, m1_we, m1_stb, m1_cyc;
  logic [DW-1:0] m0_datrd, m1_datrd, s_datrd;
  logic          m0_ack, m0_err, m1_ack, m1_err;
  logic          s_we, s_stb, s_cyc, s_ack;
  logic [1:0]    grant;

  int errors = 0;
  int checks = 0;

  wb_arbiter #(.addr_width(AW), .data_width(DW), .timeout_cycles(8)) dut (
    .clock(clock), .reset(reset),
    .m0_adr(m0_adr), .m0_datwr(m0_datwr), .m0_sel(m0_sel), .m0_we(m0_we),
    .m0_stb(m0_stb), .m0_cyc(m0_cyc), .m0_datrd(m0_datrd), .m0_ack(m0_ack),
    .m0_err(m0_err),
    .m1_adr(m1_adr), .m1_datwr(m1_datwr), .m1_sel(m1_sel), .m1_we(m1_we),
    .m1_stb(m1_stb), .m1_cyc(m1_cyc), .m1_datrd(m1_datrd), .m1_ack(m1_ack),
    .m1_err(m1_err),
    .s_adr(s_adr), .s_datwr(s_datwr), .s_sel(s_sel), .s_we(s_we),
    .s_stb(s_stb), .s_cyc(s_cyc), .s_datrd(s_datrd), .s_ack(s_ack),
    .grant(grant)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset    = 1'b0;
    m0_adr   = 32'h1000_0004; m0_datwr = 32'hDEAD_BEEF; m0_sel = 4'hF; m0_we = 1'b1;
    m1_adr   = 32'h2000_0008; m1_datwr = 32'h5555_AAAA; m1_sel = 4'h3; m1_we = 1'b0;
    m0_stb   = 1'b1; m0_cyc = 1'b1; m1_stb = 1'b1; m1_cyc = 1'b1;
    s_datrd  = 32'h1234_5678; s_ack = 1'b1;
    #1;
    // Held in reset: everything quiet despite requests and slave activity
    chk("rst_grant", 64'(grant), 64'h0);
    chk("rst_s_cyc", 64'(s_cyc), 64'h0);
    chk("rst_s_stb", 64'(s_stb), 64'h0);
    chk("rst_s_adr", 64'(s_adr), 64'h0);
    chk("rst_m0_ack", 64'(m0_ack), 64'h0);
    chk("rst_m1_datrd", 64'(m1_datrd), 64'h0);

    tick(); reset = 1'b1;
    tick();
    // Simultaneous request after reset: m0 wins, slave follows m0
    chk("first_grant", 64'(grant), 64'h1);
    chk("own0_s_adr", 64'(s_adr), 64'h1000_0004);
    chk("own0_s_datwr", 64'(s_datwr), 64'hDEAD_BEEF);
    chk("own0_s_sel", 64'(s_sel), 64'hF);
    chk("own0_s_we", 64'(s_we), 64'h1);
    chk("own0_s_stb", 64'(s_stb), 64'h1);
    chk("own0_m0_ack", 64'(m0_ack), 64'h1);
    chk("own0_m0_datrd", 64'(m0_datrd), 64'h1234_5678);
    chk("own0_m1_ack", 64'(m1_ack), 64'h0);
    chk("own0_m1_datrd", 64'(m1_datrd), 64'h0);
    tick();
    m0_cyc = 1'b0;
    #1;
    chk("drop_ack_m0", 64'(m0_ack), 64'h1);
    chk("drop_err_m0", 64'(m0_err), 64'h0);
    tick();
    chk("idle_grant", 64'(grant), 64'h0);
    chk("idle_s_cyc", 64'(s_cyc), 64'h0);
    chk("idle_s_adr", 64'(s_adr), 64'h0);
    chk("idle_s_sel", 64'(s_sel), 64'h0);
    chk("idle_m1_ack", 64'(m1_ack), 64'h0);
    tick();
    chk("own1_grant", 64'(grant), 64'h2);
    chk("own1_s_adr", 64'(s_adr), 64'h2000_0008);
    chk("own1_s_sel", 64'(s_sel), 64'h3);
    chk("own1_s_we", 64'(s_we), 64'h0);

    // Round-robin: eight single-beat transactions, both masters always requesting
    m0_cyc = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) m1_cyc = 1'b0; else m0_cyc = 1'b0;
      #1;
      chk("rr_grant", 64'(grant), (i % 2 == 0) ? 64'h2 : 64'h1);
      chk("rr_owner_ack", 64'((i % 2 == 0) ? m1_ack : m0_ack), 64'h1);
      chk("rr_other_ack", 64'((i % 2 == 0) ? m0_ack : m1_ack), 64'h0);
      tick();
      chk("rr_gap", 64'(grant), 64'h0);
      m0_cyc = 1'b1; m1_cyc = 1'b1;
      tick();
    end

    // Move to m0 ownership for a locked burst
    m1_cyc = 1'b0;
    tick();
    m1_cyc = 1'b1;
    tick();
    chk("lock_start", 64'(grant), 64'h1);
    for (int b = 0; b < 3; b++) begin
      m0_stb = 1'b1; s_ack = 1'b1;
      #1;
      chk("lock_beat_grant", 64'(grant), 64'h1);
      chk("lock_beat_ack", 64'(m0_ack), 64'h1);
      chk("lock_m1_ack", 64'(m1_ack), 64'h0);
      tick();
      m0_stb = 1'b0;
      #1;
      chk("lock_gap_grant", 64'(grant), 64'h1);
      chk("lock_gap_stb", 64'(s_stb), 64'h0);
      chk("lock_gap_m1_ack", 64'(m1_ack), 64'h0);
      tick();
    end
    m0_cyc = 1'b0; s_ack = 1'b0;
    tick();
    chk("lock_release_idle", 64'(grant), 64'h0);
    tick();
    chk("lock_then_m1", 64'(grant), 64'h2);

    // Timeout of 8: m0 owns with m1 waiting, slave silent
    m1_cyc = 1'b0; m0_cyc = 1'b1; m0_stb = 1'b1;
    tick();
    m1_cyc = 1'b1;
    tick();
    chk("to_grant", 64'(grant), 64'h1);
    for (int k = 1; k <= 8; k++) begin
      chk("to_m0_err", 64'(m0_err), (k == 8) ? 64'h1 : 64'h0);
      chk("to_s_stb", 64'(s_stb), (k == 8) ? 64'h0 : 64'h1);
      chk("to_m1_err", 64'(m1_err), 64'h0);
      tick();
    end
    chk("to_cleared", 64'(m0_err), 64'h0);
    for (int k = 0; k < 7; k++) tick();
    // Counter at its limit again: the ack arrives and must win
    s_ack = 1'b1;
    #1;
    chk("to_ack_wins_ack", 64'(m0_ack), 64'h1);
    chk("to_ack_wins_err", 64'(m0_err), 64'h0);
    chk("to_ack_wins_stb", 64'(s_stb), 64'h1);
    tick();
    s_ack = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      #1;
      chk("to_after_ack_err", 64'(m0_err), (k == 8) ? 64'h1 : 64'h0);
      tick();
    end

    // Asynchronous reset in OWN1 with a strobe pending
    m0_cyc = 1'b0; m0_stb = 1'b0;
    tick();
    tick();
    m1_stb = 1'b1;
    #1;
    chk("pre_rst_grant", 64'(grant), 64'h2);
    chk("pre_rst_s_cyc", 64'(s_cyc), 64'h1);
    #2;
    s_ack = 1'b1; reset = 1'b0;
    #1;
    chk("async_grant", 64'(grant), 64'h0);
    chk("async_s_cyc", 64'(s_cyc), 64'h0);
    chk("async_s_stb", 64'(s_stb), 64'h0);
    chk("async_m1_ack", 64'(m1_ack), 64'h0);
    chk("async_m1_err", 64'(m1_err), 64'h0);
    tick();
    m0_cyc = 1'b1; s_ack = 1'b0; reset = 1'b1;
    tick();
    chk("post_rst_tie_m0", 64'(grant), 64'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter addr_width, default 32, Wishbone address width.
REQ-002 SHALL have parameter data_width, default 32, Wishbone data width; sel width = data_width/8.
REQ-003 SHALL have parameter timeout_cycles, default 255, stalled-strobe cycles before bus error; legal range 2..255.
REQ-004 SHALL have port clock  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports m0_adr/m0_datwr/m0_sel/m0_we/m0_stb/m0_cyc  input  addr_width/data_width/data_width/8/1/1/1  master 0 (CPU) request.
REQ-007 SHALL have ports m0_datrd/m0_ack/m0_err  output  data_width/1/1  master 0 response.
REQ-008 SHALL have an identical m1_* port set  (same directions and widths)  master 1 (debug/loader) port.
REQ-009 SHALL have ports s_adr/s_datwr/s_sel/s_we/s_stb/s_cyc  output  same widths  shared slave (UART bridge) request.
REQ-010 SHALL have ports s_datrd/s_ack  input  data_width/1  shared slave response.
REQ-011 SHALL have port grant  output  2  one-hot current owner (bit0=m0, bit1=m1), 00 = none.

Function
REQ-012 SHALL implement a registered FSM with states IDLE, OWN0, OWN1; grant decodes state.
REQ-013 IDLE: m0_cyc only -> OWN0; m1_cyc only -> OWN1; both -> state not equal to last_owner (round-robin); neither -> IDLE.
REQ-014 Arbitration latency SHALL be exactly one cycle: cyc sampled in IDLE, slave sees owner's signals the next cycle.
REQ-015 OWNx: stay while mx_cyc=1; mx_cyc=0 -> IDLE and last_owner<=x; no direct OWN0<->OWN1 transition (one IDLE cycle between owners).
REQ-016 In OWNx, s_adr/s_datwr/s_sel/s_we/s_stb/s_cyc SHALL combinationally equal master x's inputs; mx_datrd=s_datrd, mx_ack=s_ack.
REQ-017 In IDLE, s_cyc=s_stb=s_we=0, s_sel=0, s_adr=s_datwr=0.
REQ-018 Non-owner master SHALL see ack=0, err=0, datrd=0, regardless of slave activity.
REQ-019 Ownership SHALL not change while owner holds cyc, including across multiple stb/ack beats (locked cycles).
REQ-020 Stall counter (8 bits) SHALL increment each cycle in OWNx with s_stb=1 and s_ack=0, clear on s_ack=1, on stb=0, or on entering IDLE.
REQ-021 When counter equals timeout_cycles-1 and s_ack=0, mx_err SHALL pulse 1 for one cycle, s_stb SHALL be forced 0 that cycle, counter clears.
REQ-022 mx_ack and mx_err SHALL never both be 1; s_ack in the timeout cycle SHALL win (ack passed, no err).
REQ-023 Owner dropping cyc in the same cycle as s_ack SHALL still receive that ack; transition to IDLE next edge.
REQ-024 last_owner SHALL update only on leaving OWNx; ties after reset favour m0.

Reset
REQ-025 reset=0 SHALL immediately force state=IDLE, grant=00, last_owner=m1, stall counter=0, all s_* request outputs 0, all m*_ack/err/datrd 0.
REQ-026 Reset asserted mid-transaction SHALL abort it with no ack/err pulse; release resumes arbitration from IDLE on the first edge after deassertion.

Verification
REQ-027 Reset release, m0_cyc=m1_cyc=1 same cycle -> grant=01 one cycle later; m0 drops cyc -> IDLE one cycle -> grant=10.
REQ-028 Both masters continuously requesting 4 single-beat transactions each -> grant sequence 01,00,10,00,01,... strictly alternating.
REQ-029 m0 locked burst of 3 beats (cyc held, stb toggled) with m1_cyc=1 throughout -> m1 never granted until m0_cyc=0; m1 m1_ack stays 0.
REQ-030 Slave never acks, timeout_cycles=8 -> m0_err=1 exactly on 8th stalled cycle, s_stb=0 that cycle, m1_err=0.
REQ-031 s_ack on the same cycle counter reaches limit -> m0_ack=1, m0_err=0.
REQ-032 reset pulsed low while OWN1 with stb pending -> s_cyc=0 and grant=00 immediately (asynchronous), no m1_ack/err.
